// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request bundle between execute/memory requesters and the arbiter
// Master side is the set of requesters; slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_wdata;

    modport master (
        output req_valid,
        output req_rd,
        output req_wdata,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_wdata,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin regfile writeback arbiter with busy scoreboard and RAW stall
// Optional operand bypass from the writeback slot is enabled by defining WB_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave req_if,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [AW-1:0]       dec_rs1,
    input  logic [AW-1:0]       dec_rs2,
    output logic                hz_stall,
`ifdef WB_ARB_BYPASS_EN
    output logic                byp_rs1_hit,
    output logic                byp_rs2_hit,
    output logic [XLEN-1:0]     byp_data,
`endif
    output logic                wb_we,
    output logic [AW-1:0]       wb_rd,
    output logic [XLEN-1:0]     wb_wdata
);
    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 2 ** AW;

    logic [PW-1:0]   r_rr_ptr;
    logic            r_wb_we;
    logic [AW-1:0]   r_wb_rd;
    logic [XLEN-1:0] r_wb_wdata;
    logic [NREG-1:0] r_busy;

    logic            w_gnt_any;
    logic [PW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_gnt_rd;
    logic [XLEN-1:0] w_gnt_wdata;
    logic [PW-1:0]   w_rr_next;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_rs1_stall;
    logic            w_rs2_stall;

    // Search starts at the round-robin pointer; the wrap is explicit so NREQ need not be a power of two.
    always_comb begin
        int idx;
        idx         = 0;
        w_gnt_any   = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_rd    = '0;
        w_gnt_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_gnt_any && req_if.req_valid[idx]) begin
                w_gnt_any   = 1'b1;
                w_gnt_idx   = PW'(idx);
                w_gnt_rd    = req_if.req_rd[idx*AW +: AW];
                w_gnt_wdata = req_if.req_wdata[idx*XLEN +: XLEN];
            end
        end
        if (reset) begin
            w_gnt_any = 1'b0;
        end
    end

    always_comb begin
        req_if.req_ready = '0;
        if (w_gnt_any) begin
            req_if.req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_rr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_wdata <= '0;
        end else if (w_gnt_any) begin
            r_rr_ptr   <= w_rr_next;
            r_wb_we    <= (w_gnt_rd != '0);
            r_wb_rd    <= w_gnt_rd;
            r_wb_wdata <= w_gnt_wdata;
        end else begin
            r_wb_we    <= 1'b0;
        end
    end

    // Clear first, then set, so a newer producer of the same index keeps it busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (r_wb_we && (r_wb_rd != '0)) begin
                r_busy[r_wb_rd] <= 1'b0;
            end
            if (iss_valid && (iss_rd != '0)) begin
                r_busy[iss_rd] <= 1'b1;
            end
        end
    end

`ifdef WB_ARB_BYPASS_EN
    assign w_rs1_hit   = r_wb_we && (r_wb_rd == dec_rs1) && (dec_rs1 != '0);
    assign w_rs2_hit   = r_wb_we && (r_wb_rd == dec_rs2) && (dec_rs2 != '0);
    assign byp_rs1_hit = w_rs1_hit;
    assign byp_rs2_hit = w_rs2_hit;
    assign byp_data    = r_wb_wdata;
`else
    assign w_rs1_hit   = 1'b0;
    assign w_rs2_hit   = 1'b0;
`endif

    assign w_rs1_stall = (dec_rs1 != '0) && r_busy[dec_rs1] && !w_rs1_hit;
    assign w_rs2_stall = (dec_rs2 != '0) && r_busy[dec_rs2] && !w_rs2_hit;
    assign hz_stall    = w_rs1_stall || w_rs2_stall;

    assign wb_we    = r_wb_we;
    assign wb_rd    = r_wb_rd;
    assign wb_wdata = r_wb_wdata;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
// Inputs change 1 time unit after posedge; all sampling happens before the next posedge.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   dec_rs1;
    logic [AW-1:0]   dec_rs2;
    logic            hz_stall;
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_wdata;
`ifdef WB_ARB_BYPASS_EN
    logic            byp_rs1_hit;
    logic            byp_rs2_hit;
    logic [XLEN-1:0] byp_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) rif ();

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_if     (rif.slave),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .hz_stall   (hz_stall),
`ifdef WB_ARB_BYPASS_EN
        .byp_rs1_hit(byp_rs1_hit),
        .byp_rs2_hit(byp_rs2_hit),
        .byp_data   (byp_data),
`endif
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_wdata   (wb_wdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        rif.req_rd[i*AW +: AW]       = rd;
        rif.req_wdata[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        logic all_clear;
        reset         = 1'b1;
        iss_valid     = 1'b0;
        iss_rd        = '0;
        dec_rs1       = '0;
        dec_rs2       = '0;
        rif.req_valid = 3'b111;
        rif.req_rd    = '0;
        rif.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), XLEN'(32'h100 + i));

        // 1: reset
        tick();
        check("rst_ready", 64'(rif.req_ready), 64'(3'b000));
        tick();
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_wb_wdata", 64'(wb_wdata), 64'd0);
        dec_rs1 = 5'd5;
        #1;
        check("rst_stall_rs1_5", 64'(hz_stall), 64'd0);
        all_clear = 1'b1;
        for (int r = 0; r < 32; r++) begin
            dec_rs1 = AW'(r);
            #1;
            if (hz_stall !== 1'b0) all_clear = 1'b0;
        end
        check("rst_busy_all_clear", 64'(all_clear), 64'd1);
        dec_rs1 = '0;
        reset   = 1'b0;

        // 2: round-robin with all requesters valid
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("rr_ready_%0d", c), 64'(rif.req_ready), 64'(3'b001 << (c % 3)));
            tick();
            check($sformatf("rr_wb_rd_%0d", c), 64'(wb_rd), 64'((c % 3) + 1));
            check($sformatf("rr_wb_we_%0d", c), 64'(wb_we), 64'd1);
        end
        rif.req_valid = 3'b000;

        // 3: single write from req0, rr_ptr back at 0
        set_req(0, 5'd7, 32'hDEAD_BEEF);
        rif.req_valid = 3'b001;
        #1;
        check("single_ready", 64'(rif.req_ready), 64'(3'b001));
        tick();
        rif.req_valid = 3'b000;
        check("single_we", 64'(wb_we), 64'd1);
        check("single_rd", 64'(wb_rd), 64'd7);
        check("single_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
        tick();
        check("single_we_drop", 64'(wb_we), 64'd0);
        check("single_rd_hold", 64'(wb_rd), 64'd7);
        check("single_wdata_hold", 64'(wb_wdata), 64'hDEAD_BEEF);

        // 4: x0 write from req1 consumes the grant, rr_ptr moves to 2
        set_req(1, 5'd0, 32'h1234);
        rif.req_valid = 3'b010;
        #1;
        check("x0_ready", 64'(rif.req_ready), 64'(3'b010));
        tick();
        rif.req_valid = 3'b000;
        check("x0_we", 64'(wb_we), 64'd0);
        check("x0_wdata", 64'(wb_wdata), 64'h1234);
        rif.req_valid = 3'b011;
        #1;
        check("x0_ptr_is_2", 64'(rif.req_ready), 64'(3'b001));
        rif.req_valid = 3'b000;
        #1;

        // 5: RAW hazard on x9, written back by req2
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        iss_valid = 1'b0;
        dec_rs1   = 5'd9;
        #1;
        check("hz_set", 64'(hz_stall), 64'd1);
        dec_rs1 = 5'd0;
        dec_rs2 = 5'd9;
        #1;
        check("hz_rs2", 64'(hz_stall), 64'd1);
        dec_rs2 = 5'd0;
        dec_rs1 = 5'd9;
        tick();
        check("hz_hold", 64'(hz_stall), 64'd1);
        set_req(2, 5'd9, 32'h55);
        rif.req_valid = 3'b100;
        #1;
        check("hz_wb_ready", 64'(rif.req_ready), 64'(3'b100));
        tick();
        rif.req_valid = 3'b000;
        check("hz_wb_we", 64'(wb_we), 64'd1);
        check("hz_wb_rd", 64'(wb_rd), 64'd9);
`ifdef WB_ARB_BYPASS_EN
        check("hz_wb_cycle_bypass", 64'(hz_stall), 64'd0);
        check("byp_rs1_hit", 64'(byp_rs1_hit), 64'd1);
        check("byp_rs2_hit", 64'(byp_rs2_hit), 64'd0);
        check("byp_data", 64'(byp_data), 64'h55);
`else
        check("hz_wb_cycle", 64'(hz_stall), 64'd1);
`endif
        tick();
        check("hz_clear", 64'(hz_stall), 64'd0);

        // 6: set/clear collision on x4, rr_ptr now 0
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        tick();
        iss_valid = 1'b0;
        set_req(0, 5'd4, 32'h4444);
        rif.req_valid = 3'b001;
        #1;
        check("col_ready", 64'(rif.req_ready), 64'(3'b001));
        tick();
        rif.req_valid = 3'b000;
        check("col_wb_rd", 64'(wb_rd), 64'd4);
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        tick();
        iss_valid = 1'b0;
        dec_rs1   = 5'd4;
        #1;
        check("col_set_wins", 64'(hz_stall), 64'd1);

        // mid-stream reset with x4, x10 busy, rr_ptr at 1 and a grant pending
        iss_valid = 1'b1;
        iss_rd    = 5'd10;
        tick();
        iss_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 20), XLEN'(i));
        rif.req_valid = 3'b111;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(rif.req_ready), 64'(3'b000));
        tick();
        reset = 1'b0;
        rif.req_valid = 3'b000;
        check("mid_rst_we", 64'(wb_we), 64'd0);
        dec_rs1 = 5'd4;
        dec_rs2 = 5'd10;
        #1;
        check("mid_rst_busy", 64'(hz_stall), 64'd0);
        rif.req_valid = 3'b101;
        #1;
        check("mid_rst_ptr", 64'(rif.req_ready), 64'(3'b001));
        rif.req_valid = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
